// File: rtl/demux_pkg.sv
// demux_pkg: shared channel count, select width and FSM state type for the 1-to-4 stream demux.
package demux_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W = 2;
  typedef enum logic {ST_IDLE, ST_BUSY} state_t;
endpackage

// File: rtl/demux1to4_stream_if.sv
// demux1to4_stream_if: producer-side stream plus four consumer channels of the demux.
interface demux1to4_stream_if #(parameter int DW = 8);
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_last;
  logic [1:0]      in_sel;
  logic            in_ready;
  logic [4*DW-1:0] out_data;
  logic [3:0]      out_valid;
  logic [3:0]      out_last;
  logic [3:0]      out_ready;
  modport master (output in_data, in_valid, in_last, in_sel, out_ready,
                  input in_ready, out_data, out_valid, out_last);
  modport slave (input in_data, in_valid, in_last, in_sel, out_ready,
                 output in_ready, out_data, out_valid, out_last);
endinterface

// File: rtl/demux_out_slice.sv
// demux_out_slice: one-entry registered output stage; a load wins over a same-cycle drain.
module demux_out_slice #(parameter int DW = 8) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] d,
  input  logic          last,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] q,
  output logic          q_last
);
  logic          r_valid;
  logic [DW-1:0] r_q;
  logic          r_last;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_q     <= '0;
      r_last  <= 1'b0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_q     <= d;
      r_last  <= last;
    end else if (ready) begin
      r_valid <= 1'b0;
    end
  end
  assign valid  = r_valid;
  assign q      = r_q;
  assign q_last = r_last;
endmodule

// File: rtl/demux1to4_stream.sv
// demux1to4_stream: routes one valid/ready stream to one of four registered channels.
// Define DEMUX1TO4_PKT_LOCK_EN to pin every beat of a packet to its first beat's channel.
module demux1to4_stream
  import demux_pkg::*;
#(
  parameter int DW = 8
) (
  input logic clk,
  input logic rst_n,
  demux1to4_stream_if.slave bus
);
  logic [SEL_W-1:0]  w_dst;
  logic              w_ready;
  logic              w_acc;
  logic [NUM_CH-1:0] w_valid;
  logic [NUM_CH-1:0] w_last;
  logic [DW-1:0]     w_q [NUM_CH];
`ifdef DEMUX1TO4_PKT_LOCK_EN
  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_lock_sel, w_lock_nxt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_lock_sel <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_sel <= w_lock_nxt;
    end
  end
  assign w_dst = (r_state == ST_BUSY) ? r_lock_sel : bus.in_sel;
  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock_sel;
    if (w_acc) begin
      w_state_nxt = bus.in_last ? ST_IDLE : ST_BUSY;
      if (r_state == ST_IDLE && !bus.in_last) w_lock_nxt = bus.in_sel;
    end
  end
`else
  assign w_dst = bus.in_sel;
`endif
  // Readiness looks only at the chosen channel, so idle channels never stall the producer.
  assign w_ready       = rst_n & (~w_valid[w_dst] | bus.out_ready[w_dst]);
  assign w_acc         = bus.in_valid & w_ready;
  assign bus.in_ready  = w_ready;
  assign bus.out_valid = w_valid;
  assign bus.out_last  = w_last;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    demux_out_slice #(.DW(DW)) u_slice (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (w_acc && (w_dst == SEL_W'(k))),
      .d      (bus.in_data),
      .last   (bus.in_last),
      .ready  (bus.out_ready[k]),
      .valid  (w_valid[k]),
      .q      (w_q[k]),
      .q_last (w_last[k])
    );
    assign bus.out_data[k*DW +: DW] = w_q[k];
  end
endmodule
